// File: rtl/stage_wback_ext.sv
// ---------------------------------------------------------------------------
// stage_wback_ext -- writeback (W) stage of the in-order core.
//
// Registers the memory-stage bundle into the W pipeline register (supports
// stall, flush and a valid bit), extracts and sign/zero-extends load data,
// selects the writeback result (ALU / load / PC+4 / CSR) and drives the
// register-file write port, which also serves as the WB forwarding path.
//
// Optional feature: define RETIRE_CNT_EN to add the retireCount output, a
// CNT_W-bit count of instructions leaving W. Without the macro the port
// and the counter are absent.
//
// Parameters:
//   XLEN       datapath width, 32 or 64
//   REG_ADDR_W register address width
//   CNT_W      retire counter width (only meaningful with RETIRE_CNT_EN)
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   stallW       hold the W register
//   flushW       load a bubble into W (wins over stallW)
//   validM       M bundle is a real instruction
//   regWriteM    instruction writes rd
//   regSrcM      result source: 00 ALU, 01 MEM, 10 PC+4, 11 CSR
//   loadTypeM    RISC-V load funct3
//   rdAddrM      destination register
//   aluResultM   ALU result, also the load address
//   readDataM    raw aligned memory word
//   pcPlus4M     PC+4
//   csrDataM     CSR read value
//   regWrite     register-file write enable (never for x0)
//   rdAddr       register-file write address
//   result       writeback / forwarding data
//   validW       W holds a valid instruction
//   retireCount  retired-instruction count (RETIRE_CNT_EN only)
// ---------------------------------------------------------------------------
module stage_wback_ext #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stallW,
    input  logic                  flushW,
    input  logic                  validM,
    input  logic                  regWriteM,
    input  logic [1:0]            regSrcM,
    input  logic [2:0]            loadTypeM,
    input  logic [REG_ADDR_W-1:0] rdAddrM,
    input  logic [XLEN-1:0]       aluResultM,
    input  logic [XLEN-1:0]       readDataM,
    input  logic [XLEN-1:0]       pcPlus4M,
    input  logic [XLEN-1:0]       csrDataM,
    output logic                  regWrite,
    output logic [REG_ADDR_W-1:0] rdAddr,
    output logic [XLEN-1:0]       result,
    output logic                  validW
`ifdef RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]      retireCount
`endif
);

    // Byte-offset width inside one XLEN word (2 for RV32, 3 for RV64).
    localparam int OFF_W = $clog2(XLEN / 8);

    if (!(XLEN == 32 || XLEN == 64) || CNT_W < 1) begin : g_param_check
        $error("stage_wback_ext: XLEN must be 32 or 64 and CNT_W at least 1");
    end

    typedef enum logic [1:0] {
        SRC_ALU = 2'b00,
        SRC_MEM = 2'b01,
        SRC_PC4 = 2'b10,
        SRC_CSR = 2'b11
    } src_e;

    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_D  = 3'b011,
        LD_BU = 3'b100,
        LD_HU = 3'b101,
        LD_WU = 3'b110
    } load_e;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        src_e                  src;
        load_e                 load_type;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       alu;
        logic [XLEN-1:0]       rdata;
        logic [XLEN-1:0]       pc4;
        logic [XLEN-1:0]       csr;
    } w_bundle_t;

    w_bundle_t m_bundle;
    w_bundle_t w_q;

    assign m_bundle = '{
        valid:     validM,
        reg_write: regWriteM,
        src:       src_e'(regSrcM),
        load_type: load_e'(loadTypeM),
        rd:        rdAddrM,
        alu:       aluResultM,
        rdata:     readDataM,
        pc4:       pcPlus4M,
        csr:       csrDataM
    };

    // W pipeline register: rst > flushW > stallW > capture. A flush only
    // needs to kill valid/regWrite; the payload fields simply hold.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_q <= '0;
        end else if (flushW) begin
            w_q.valid     <= 1'b0;
            w_q.reg_write <= 1'b0;
        end else if (!stallW) begin
            w_q <= m_bundle;
        end
    end

    // Load lane extraction. Offset low bits select the lane; halfword
    // drops bit 0, word (RV64) uses only the top offset bit, so misaligned
    // addresses are silently truncated rather than trapped.
    logic [OFF_W-1:0] off;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;
    logic [31:0]      lane_w;
    logic [XLEN-1:0]  load_data;

    // NOTE: every variable written in an always_comb gets a default first,
    // so no path through the case statements can infer a latch.
    always_comb begin
        off       = w_q.alu[OFF_W-1:0];
        lane_b    = 8'(w_q.rdata >> {off, 3'b000});
        lane_h    = 16'(w_q.rdata >> {off[OFF_W-1:1], 4'b0000});
        // For RV32 both halves of this select are the same word.
        lane_w    = off[OFF_W-1] ? w_q.rdata[XLEN-1 -: 32] : w_q.rdata[31:0];
        load_data = w_q.rdata;
        case (w_q.load_type)
            LD_B:    load_data = XLEN'($signed(lane_b));
            LD_BU:   load_data = XLEN'(lane_b);
            LD_H:    load_data = XLEN'($signed(lane_h));
            LD_HU:   load_data = XLEN'(lane_h);
            LD_W:    load_data = XLEN'($signed(lane_w));
            // LWU only exists on RV64; RV32 passes the raw word through.
            LD_WU:   load_data = (XLEN == 64) ? XLEN'(lane_w) : w_q.rdata;
            default: load_data = w_q.rdata;   // LD and funct3 111
        endcase
    end

    always_comb begin
        result = w_q.alu;
        case (w_q.src)
            SRC_ALU: result = w_q.alu;
            SRC_MEM: result = load_data;
            SRC_PC4: result = w_q.pc4;
            SRC_CSR: result = w_q.csr;
            default: result = w_q.alu;
        endcase
    end

    // x0 is hard-wired zero, so a write to it is never issued.
    assign regWrite = w_q.reg_write & w_q.valid & (w_q.rd != '0);
    assign rdAddr   = w_q.rd;
    assign validW   = w_q.valid;

`ifdef RETIRE_CNT_EN
    // An instruction leaves W when it is valid and W is either advancing
    // or being flushed; a stalled instruction is counted once it moves on.
    logic [CNT_W-1:0] retire_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q <= '0;
        end else if (w_q.valid && (!stallW || flushW)) begin
            retire_q <= retire_q + CNT_W'(1);
        end
    end

    assign retireCount = retire_q;
`endif

endmodule

// File: tb/tb_stage_wback_ext.sv
// ---------------------------------------------------------------------------
// Testbench for stage_wback_ext. Instantiates an RV32 and an RV64 copy fed
// from the same stimulus and compares both against a behavioural model.
// ---------------------------------------------------------------------------
module tb_stage_wback_ext;

    localparam int TB_CNT_W = 4;   // small so the wrap is reachable

    logic        clk = 1'b0;
    logic        rst;
    logic        stallW, flushW, validM, regWriteM;
    logic [1:0]  regSrcM;
    logic [2:0]  loadTypeM;
    logic [4:0]  rdAddrM;
    logic [63:0] aluM, rdataM, pc4M, csrM;

    logic        rw32, v32, rw64, v64;
    logic [4:0]  rd32, rd64;
    logic [31:0] res32;
    logic [63:0] res64;
`ifdef RETIRE_CNT_EN
    logic [TB_CNT_W-1:0] cnt32, cnt64;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    stage_wback_ext #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(TB_CNT_W)) dut32 (
        .clk(clk), .rst(rst), .stallW(stallW), .flushW(flushW),
        .validM(validM), .regWriteM(regWriteM), .regSrcM(regSrcM),
        .loadTypeM(loadTypeM), .rdAddrM(rdAddrM),
        .aluResultM(aluM[31:0]), .readDataM(rdataM[31:0]),
        .pcPlus4M(pc4M[31:0]), .csrDataM(csrM[31:0]),
        .regWrite(rw32), .rdAddr(rd32), .result(res32), .validW(v32)
`ifdef RETIRE_CNT_EN
        , .retireCount(cnt32)
`endif
    );

    stage_wback_ext #(.XLEN(64), .REG_ADDR_W(5), .CNT_W(TB_CNT_W)) dut64 (
        .clk(clk), .rst(rst), .stallW(stallW), .flushW(flushW),
        .validM(validM), .regWriteM(regWriteM), .regSrcM(regSrcM),
        .loadTypeM(loadTypeM), .rdAddrM(rdAddrM),
        .aluResultM(aluM), .readDataM(rdataM),
        .pcPlus4M(pc4M), .csrDataM(csrM),
        .regWrite(rw64), .rdAddr(rd64), .result(res64), .validW(v64)
`ifdef RETIRE_CNT_EN
        , .retireCount(cnt64)
`endif
    );

    // Reference model of the writeback value, from the ISA load rules.
    function automatic logic [63:0] model_result(input int xlen, input logic [1:0] src,
                                                 input logic [2:0] f3, input logic [63:0] alu,
                                                 input logic [63:0] rdata, input logic [63:0] pc4,
                                                 input logic [63:0] csr);
        logic [63:0] mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        int          nb   = xlen / 8;
        int          off  = int'(alu[5:0]) % nb;
        logic [63:0] d    = rdata & mask;
        logic [63:0] v;
        case (src)
            2'd0: v = alu;
            2'd2: v = pc4;
            2'd3: v = csr;
            default: begin
                case (f3)
                    3'd0: begin
                        v = (d >> (8 * off)) & 64'hFF;
                        if (v >= 64'h80) v = v - 64'h100;
                    end
                    3'd4: v = (d >> (8 * off)) & 64'hFF;
                    3'd1: begin
                        v = (d >> (8 * (off - off % 2))) & 64'hFFFF;
                        if (v >= 64'h8000) v = v - 64'h1_0000;
                    end
                    3'd5: v = (d >> (8 * (off - off % 2))) & 64'hFFFF;
                    3'd2: begin
                        if (xlen == 32) v = d;
                        else begin
                            v = (d >> (8 * (off - off % 4))) & 64'hFFFF_FFFF;
                            if (v >= 64'h8000_0000) v = v - 64'h1_0000_0000;
                        end
                    end
                    3'd6: v = (xlen == 32) ? d : ((d >> (8 * (off - off % 4))) & 64'hFFFF_FFFF);
                    default: v = d;
                endcase
            end
        endcase
        return v & mask;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input logic v, input logic rw, input logic [4:0] rd,
                           input logic [1:0] src, input logic [2:0] f3,
                           input logic [63:0] alu, input logic [63:0] rdata,
                           input logic [63:0] pc4, input logic [63:0] csr);
        validM = v; regWriteM = rw; rdAddrM = rd; regSrcM = src; loadTypeM = f3;
        aluM = alu; rdataM = rdata; pc4M = pc4; csrM = csr;
    endtask

    task automatic test_reset();
        rst = 1'b1; stallW = 1'b0; flushW = 1'b0;
        drive_m(1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 64'h55, 64'h66, 64'h77, 64'h88);
        tick(); tick();
        n_checks++; if ({rw32, v32, rd32, res32} !== '0) $display("FAIL reset32: got rw=%b v=%b rd=%0d res=%h want all 0", rw32, v32, rd32, res32); else n_pass++;
        n_checks++; if ({rw64, v64, rd64, res64} !== '0) $display("FAIL reset64: got rw=%b v=%b rd=%0d res=%h want all 0", rw64, v64, rd64, res64); else n_pass++;
`ifdef RETIRE_CNT_EN
        n_checks++; if ({cnt32, cnt64} !== '0) $display("FAIL reset_cnt: got %0d/%0d want 0", cnt32, cnt64); else n_pass++;
`endif
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        drive_m(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 64'h1234_5678, 64'h0, 64'h0, 64'h0);
        tick();
        n_checks++; if (rw32 !== 1'b1 || v32 !== 1'b1) $display("FAIL pass_ctrl: got rw=%b v=%b want 1 1", rw32, v32); else n_pass++;
        n_checks++; if (rd32 !== 5'd5) $display("FAIL pass_rd: got %0d want 5", rd32); else n_pass++;
        n_checks++; if (res32 !== 32'h1234_5678) $display("FAIL pass_res32: got %h want 12345678", res32); else n_pass++;
        n_checks++; if (res64 !== 64'h1234_5678) $display("FAIL pass_res64: got %h want 12345678", res64); else n_pass++;
    endtask

    task automatic test_load_ext();
        logic [2:0]  ft  [4];
        logic [63:0] ad  [4];
        logic [31:0] exp [4];
        ft  = '{3'd0, 3'd4, 3'd1, 3'd5};
        ad  = '{64'd3, 64'd2, 64'd2, 64'd0};
        exp = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01};
        for (int i = 0; i < 4; i++) begin
            drive_m(1'b1, 1'b1, 5'd1, 2'd1, ft[i], ad[i], 64'h80FF_7F01, 64'h0, 64'h0);
            tick();
            n_checks++; if (res32 !== exp[i]) $display("FAIL load_ext f3=%0d off=%0d: got %h want %h", ft[i], ad[i], res32, exp[i]); else n_pass++;
        end
    endtask

    task automatic test_stall_flush();
        drive_m(1'b1, 1'b1, 5'd7, 2'd0, 3'd0, 64'hA, 64'h0, 64'h0, 64'h0);
        tick();
        stallW = 1'b1;
        drive_m(1'b1, 1'b1, 5'd9, 2'd0, 3'd0, 64'h55, 64'h0, 64'h0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (rd32 !== 5'd7 || res32 !== 32'hA || rw32 !== 1'b1) $display("FAIL stall_hold %0d: got rd=%0d res=%h rw=%b want 7 a 1", i, rd32, res32, rw32); else n_pass++;
        end
        flushW = 1'b1;
        tick();
        n_checks++; if (v32 !== 1'b0 || rw32 !== 1'b0 || v64 !== 1'b0 || rw64 !== 1'b0) $display("FAIL flush: got v=%b rw=%b v64=%b rw64=%b want 0", v32, rw32, v64, rw64); else n_pass++;
        stallW = 1'b0; flushW = 1'b0;
    endtask

    task automatic test_x0_sources();
        drive_m(1'b1, 1'b1, 5'd0, 2'd0, 3'd0, 64'h99, 64'h0, 64'h0, 64'h0);
        tick();
        n_checks++; if (rw32 !== 1'b0 || v32 !== 1'b1) $display("FAIL x0: got rw=%b v=%b want 0 1", rw32, v32); else n_pass++;
        drive_m(1'b1, 1'b1, 5'd2, 2'd2, 3'd0, 64'h99, 64'h0, 64'h104, 64'h0);
        tick();
        n_checks++; if (res32 !== 32'h104) $display("FAIL src_pc4: got %h want 104", res32); else n_pass++;
        drive_m(1'b1, 1'b1, 5'd2, 2'd3, 3'd0, 64'h99, 64'h0, 64'h104, 64'hDEAD);
        tick();
        n_checks++; if (res32 !== 32'hDEAD || res64 !== 64'hDEAD) $display("FAIL src_csr: got %h/%h want dead", res32, res64); else n_pass++;
    endtask

    task automatic test_xlen64();
        logic [63:0] rd_word;
        rd_word = 64'h8000_0001_FFFF_FFFE;
        drive_m(1'b1, 1'b1, 5'd4, 2'd1, 3'd2, 64'd4, rd_word, 64'h0, 64'h0);
        tick();
        n_checks++; if (res64 !== 64'hFFFF_FFFF_8000_0001) $display("FAIL lw64: got %h want ffffffff80000001", res64); else n_pass++;
        drive_m(1'b1, 1'b1, 5'd4, 2'd1, 3'd6, 64'd0, rd_word, 64'h0, 64'h0);
        tick();
        n_checks++; if (res64 !== 64'h0000_0000_FFFF_FFFE) $display("FAIL lwu64: got %h want 00000000fffffffe", res64); else n_pass++;
        n_checks++; if (res32 !== 32'hFFFF_FFFE) $display("FAIL lwu32_raw: got %h want fffffffe", res32); else n_pass++;
        drive_m(1'b1, 1'b1, 5'd4, 2'd1, 3'd3, 64'd5, rd_word, 64'h0, 64'h0);
        tick();
        n_checks++; if (res64 !== rd_word) $display("FAIL ld64: got %h want %h", res64, rd_word); else n_pass++;
    endtask

`ifdef RETIRE_CNT_EN
    task automatic test_retire();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            stallW = (c == 4 || c == 8);
            drive_m(1'b1, 1'b1, 5'(c + 1), 2'd0, 3'd0, 64'(c), 64'h0, 64'h0, 64'h0);
            tick();
        end
        stallW = 1'b0;
        drive_m(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 64'h0, 64'h0, 64'h0, 64'h0);
        tick();
        n_checks++; if (cnt32 !== 4'd10 || cnt64 !== 4'd10) $display("FAIL retire10: got %0d/%0d want 10", cnt32, cnt64); else n_pass++;
        flushW = 1'b1;
        drive_m(1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 64'h0, 64'h0, 64'h0, 64'h0);
        tick();
        flushW = 1'b0;
        drive_m(1'b0, 1'b1, 5'd3, 2'd0, 3'd0, 64'h0, 64'h0, 64'h0, 64'h0);
        tick();
        n_checks++; if (cnt32 !== 4'd10 || cnt64 !== 4'd10) $display("FAIL retire_bubble: got %0d/%0d want 10", cnt32, cnt64); else n_pass++;
        for (int c = 0; c < 6; c++) begin
            drive_m(1'b1, 1'b1, 5'd1, 2'd0, 3'd0, 64'h0, 64'h0, 64'h0, 64'h0);
            tick();
        end
        drive_m(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 64'h0, 64'h0, 64'h0, 64'h0);
        tick();
        n_checks++; if (cnt32 !== 4'd0 || cnt64 !== 4'd0) $display("FAIL retire_wrap: got %0d/%0d want 0", cnt32, cnt64); else n_pass++;
    endtask
`endif

    typedef struct {
        logic        valid, rw, known;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [63:0] alu, rdata, pc4, csr;
    } wmodel_t;

    task automatic test_random();
        wmodel_t     m;
        logic [63:0] e64;
        int          cnt;
        rst = 1'b1; stallW = 1'b0; flushW = 1'b0;
        tick();
        rst = 1'b0;
        m = '{valid: 1'b0, rw: 1'b0, known: 1'b1, rd: 5'd0, src: 2'd0, f3: 3'd0,
              alu: 64'h0, rdata: 64'h0, pc4: 64'h0, csr: 64'h0};
        cnt = 0;
        for (int c = 0; c < 300; c++) begin
            stallW = ($urandom_range(0, 4) == 0);
            flushW = ($urandom_range(0, 9) == 0);
            drive_m($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, 5'($urandom),
                    2'($urandom), 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom});
            if (m.valid && (!stallW || flushW)) cnt = (cnt + 1) % (1 << TB_CNT_W);
            if (flushW) begin
                m.valid = 1'b0; m.rw = 1'b0; m.known = 1'b0;
            end else if (!stallW) begin
                m = '{valid: validM, rw: regWriteM, known: 1'b1, rd: rdAddrM, src: regSrcM,
                      f3: loadTypeM, alu: aluM, rdata: rdataM, pc4: pc4M, csr: csrM};
            end
            tick();
            n_checks++; if (v32 !== m.valid || v64 !== m.valid) $display("FAIL rnd_valid c=%0d: got %b/%b want %b", c, v32, v64, m.valid); else n_pass++;
            n_checks++; if (rw32 !== (m.rw && m.valid && m.rd != 0) || rw64 !== rw32) $display("FAIL rnd_regwrite c=%0d: got %b/%b want %b", c, rw32, rw64, m.rw && m.valid && m.rd != 0); else n_pass++;
            if (m.known) begin
                n_checks++; if (rd32 !== m.rd || rd64 !== m.rd) $display("FAIL rnd_rd c=%0d: got %0d/%0d want %0d", c, rd32, rd64, m.rd); else n_pass++;
                e64 = model_result(32, m.src, m.f3, m.alu, m.rdata, m.pc4, m.csr);
                n_checks++; if (res32 !== e64[31:0]) $display("FAIL rnd_res32 c=%0d src=%0d f3=%0d: got %h want %h", c, m.src, m.f3, res32, e64[31:0]); else n_pass++;
                e64 = model_result(64, m.src, m.f3, m.alu, m.rdata, m.pc4, m.csr);
                n_checks++; if (res64 !== e64) $display("FAIL rnd_res64 c=%0d src=%0d f3=%0d: got %h want %h", c, m.src, m.f3, res64, e64); else n_pass++;
            end
`ifdef RETIRE_CNT_EN
            n_checks++; if (cnt32 !== TB_CNT_W'(cnt) || cnt64 !== TB_CNT_W'(cnt)) $display("FAIL rnd_cnt c=%0d: got %0d/%0d want %0d", c, cnt32, cnt64, cnt); else n_pass++;
`endif
        end
        stallW = 1'b0; flushW = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stallW = 1'b0; flushW = 1'b0;
        drive_m(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 64'h0, 64'h0, 64'h0, 64'h0);
        test_reset();
        test_passthrough();
        test_load_ext();
        test_stall_flush();
        test_x0_sources();
        test_xlen64();
`ifdef RETIRE_CNT_EN
        test_retire();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stage_wback_ext.md
Name: stage_wback_ext

Overview:
Parametrised next-generation writeback stage for the in-order core. It registers the memory-stage bundle and supports stall, flush and a valid bit. It performs load byte/half extraction with sign/zero extension and adds a CSR result source. It drives the register-file write port and the WB forwarding path, with an optional retired-instruction counter.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
REG_ADDR_W, 5, register address width.
CNT_W, 64, retire counter width; only used with the optional feature.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
stallW  input  1  hold the W pipeline register
flushW  input  1  load a bubble into the W register; overrides stallW
validM  input  1  M-stage bundle is a real instruction
regWriteM  input  1  instruction writes rd
regSrcM  input  2  result source: 00 ALU, 01 MEM, 10 PC+4, 11 CSR
loadTypeM  input  3  RISC-V load funct3 (000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU)
rdAddrM  input  REG_ADDR_W  destination register
aluResultM  input  XLEN  ALU result; also the load address
readDataM  input  XLEN  raw aligned memory word
pcPlus4M  input  XLEN  PC+4
csrDataM  input  XLEN  CSR read value
regWrite  output  1  register-file write enable
rdAddr  output  REG_ADDR_W  register-file write address
result  output  XLEN  writeback data; also the forwarding value
validW  output  1  W holds a valid instruction
retireCount  output  CNT_W  retired count; present only with RETIRE_CNT_EN

Behaviour:
- Reset: all W registers are 0. Outputs are then regWrite=0, validW=0, rdAddr=0, result=0, retireCount=0.
- Register update priority, per posedge: rst > flushW > stallW > capture.
  - flushW: validSv=0 and regWriteSv=0; other fields are don't-care.
  - stallW without flushW: all fields hold.
  - Otherwise: capture all *M inputs.
- Latency: 1 cycle from M inputs to W outputs.
- regWrite = regWriteSv & validSv & (rdAddrSv != 0). A write to x0 is never issued.
- While stalled, regWrite stays asserted with identical data. The register file tolerates the repeated write.
- result is combinational from the registered fields, by regSrcSv:
  - 00: aluResultSv.
  - 01: load-extended data (see below).
  - 10: pcPlus4Sv.
  - 11: csrDataSv.
- Load extraction uses off = aluResultSv[log2(XLEN/8)-1:0] to select a lane of readDataSv.
  - LB/LBU: byte at lane off, sign-/zero-extended to XLEN.
  - LH/LHU: halfword at off with bit0 ignored, sign-/zero-extended.
  - LW: XLEN=32 passes the word; XLEN=64 selects the word by off[2] and sign-extends.
  - LWU/LD: valid only when XLEN=64. With XLEN=32, and for funct3 111, result is readDataSv unmodified.
  - Misaligned offsets are not trapped here; the low offset bits are truncated as described.
- When validSv=0, result still follows the registered fields. Consumers must qualify with validW.

Optional Feature:
RETIRE_CNT_EN.
- Defined: retireCount is a CNT_W-bit counter, reset to 0. It increments by 1 on each posedge where validSv=1 and (stallW=0 or flushW=1), i.e. once per instruction leaving W. It wraps from all-ones to 0.
- Not defined: the retireCount port and the counter logic are absent.

Test Plan:
1. Reset and basic pass-through: assert rst for 2 cycles, check all outputs are 0. Then validM=1, regWriteM=1, rd=5, regSrc=00, alu=0x1234_5678. Next cycle expect regWrite=1, rdAddr=5, result=0x1234_5678, validW=1.
2. Load extension: regSrc=01, readData=0x80FF_7F01.
   - LB with alu[1:0]=3 -> 0xFFFF_FF80.
   - LBU with alu[1:0]=2 -> 0x0000_00FF.
   - LH with alu[1:0]=2 -> 0xFFFF_80FF.
   - LHU with alu[1:0]=0 -> 0x0000_7F01.
3. Stall and flush:
   - Capture rd=7, result=0xA. Hold stallW=1 for 3 cycles while M changes to rd=9; expect rd=7 and result=0xA held.
   - Assert stallW=1 with flushW=1; next cycle expect validW=0 and regWrite=0.
4. x0 suppression and sources:
   - rd=0 with regWriteM=1 -> regWrite=0.
   - regSrc=10 with pcPlus4=0x104 -> result=0x104.
   - regSrc=11 with csr=0xDEAD -> result=0xDEAD.
5. RETIRE_CNT_EN:
   - 10 valid instructions with 2 stall cycles inserted -> retireCount=10.
   - 1 flushed bubble plus 1 invalid M -> count unchanged.
   - Preload counter to all-ones, retire 1 -> 0.
6. XLEN=64: readData=0x8000_0001_FFFF_FFFE.
   - LW with alu[2:0]=4 -> 0xFFFF_FFFF_8000_0001.
   - LWU with alu[2:0]=0 -> 0x0000_0000_FFFF_FFFE.
   - LD -> full word.
